// File: rtl/apple1_pkg.sv
// Shared RAM-arbitration definitions: read-tag encoding, RAM address width and
// the throttle-counter width helper.
package apple1_pkg;

   localparam int unsigned RAM_ADDR_WIDTH = 13;

   typedef enum logic [1:0] {
      TAG_NONE   = 2'd0,
      TAG_CPU_RD = 2'd1,
      TAG_DMA_RD = 2'd2
   } tag_e;

   // Unlimited mode (0) still needs a 1-bit counter to stay legal
   function automatic int unsigned cnt_width(input int unsigned max_per_slot);
      return (max_per_slot == 0) ? 1 : $clog2(max_per_slot + 1);
   endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// CPU, DMA and RAM-side signals of the RAM port arbiter. The master modport is the
// requester/RAM environment; the slave modport is the arbiter itself.
interface ram_port_arbiter_if
   import apple1_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH
);
   logic                  cpu_clken;
   logic                  cpu_cs;
   logic                  cpu_we;
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [7:0]            cpu_wdata;
   logic [7:0]            cpu_rdata;
   logic                  dma_req;
   logic                  dma_we;
   logic [ADDR_WIDTH-1:0] dma_addr;
   logic [7:0]            dma_wdata;
   logic                  dma_ack;
   logic [7:0]            dma_rdata;
   logic                  dma_rvalid;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  ram_w_en;
   logic [7:0]            ram_din;
   logic [7:0]            ram_dout;

   modport master (
      output cpu_clken, cpu_cs, cpu_we, cpu_addr, cpu_wdata,
      output dma_req, dma_we, dma_addr, dma_wdata,
      output ram_dout,
      input  cpu_rdata, dma_ack, dma_rdata, dma_rvalid,
      input  ram_addr, ram_w_en, ram_din
   );

   modport slave (
      input  cpu_clken, cpu_cs, cpu_we, cpu_addr, cpu_wdata,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      input  ram_dout,
      output cpu_rdata, dma_ack, dma_rdata, dma_rvalid,
      output ram_addr, ram_w_en, ram_din
   );

endinterface

// File: rtl/ram_port_arbiter.sv
// Shares the single-port system RAM between the CPU (fixed cpu_clken slot) and a
// throttled DMA port; read data is steered back to its owner by a registered tag.
module ram_port_arbiter
   import apple1_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH       = RAM_ADDR_WIDTH,
   parameter int unsigned DMA_MAX_PER_SLOT = 8
) (
   input logic               clk25,
   input logic               reset,
   ram_port_arbiter_if.slave bus
);

   localparam int unsigned     CntW   = cnt_width(DMA_MAX_PER_SLOT);
   localparam logic [CntW-1:0] CntMax = CntW'(DMA_MAX_PER_SLOT);

   tag_e                  tag_q, tag_d;
   logic [CntW-1:0]       count_q, count_d;
   logic [7:0]            cpu_rdata_q, dma_rdata_q;
   logic                  dma_rvalid_q;
   logic                  cpu_own, dma_own, throttled;
   logic [ADDR_WIDTH-1:0] addr_mux;
   logic                  w_en_mux;
   logic [7:0]            din_mux;

   always_comb begin
      throttled = (DMA_MAX_PER_SLOT != 0) && (count_q == CntMax);
      cpu_own   = bus.cpu_clken & bus.cpu_cs;
      // The clken cycle stays reserved for the CPU even when it is not selecting RAM
      dma_own   = bus.dma_req & ~bus.cpu_clken & ~throttled & ~reset;

      addr_mux = bus.cpu_addr;
      w_en_mux = 1'b0;
      din_mux  = bus.cpu_wdata;
      tag_d    = TAG_NONE;
      if (cpu_own) begin
         w_en_mux = bus.cpu_we;
         tag_d    = bus.cpu_we ? TAG_NONE : TAG_CPU_RD;
      end else if (dma_own) begin
         addr_mux = bus.dma_addr;
         w_en_mux = bus.dma_we;
         din_mux  = bus.dma_wdata;
         tag_d    = bus.dma_we ? TAG_NONE : TAG_DMA_RD;
      end

      count_d = count_q;
      if (bus.cpu_clken) begin
         count_d = '0;
      end else if (dma_own && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk25) begin
      if (reset) begin
         tag_q        <= TAG_NONE;
         count_q      <= '0;
         cpu_rdata_q  <= 8'h00;
         dma_rdata_q  <= 8'h00;
         dma_rvalid_q <= 1'b0;
      end else begin
         tag_q        <= tag_d;
         count_q      <= count_d;
         dma_rvalid_q <= (tag_q == TAG_DMA_RD);
         if (tag_q == TAG_CPU_RD) cpu_rdata_q <= bus.ram_dout;
         if (tag_q == TAG_DMA_RD) dma_rdata_q <= bus.ram_dout;
      end
   end

   assign bus.ram_addr   = addr_mux;
   assign bus.ram_w_en   = w_en_mux;
   assign bus.ram_din    = din_mux;
   assign bus.dma_ack    = dma_own;
   assign bus.cpu_rdata  = cpu_rdata_q;
   assign bus.dma_rdata  = dma_rdata_q;
   assign bus.dma_rvalid = dma_rvalid_q;

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the single-port synchronous 8 KiB system RAM between the 6502 and one secondary requester: a DMA-style port used by the planned video fetcher and UART hex loader. Sits between the CPU bus decode and the `ram` instance in the top level. The CPU always owns the RAM in its `cpu_clken` cycle. The DMA port is granted single-cycle accesses in the remaining cycles, throttled per CPU period. Read data for each owner is captured and held, so neither side sees the other's traffic on its data bus.

## Interface
- `ADDR_WIDTH`, 13, RAM address width (0x0000–0x1FFF).
- `DMA_MAX_PER_SLOT`, 8, maximum DMA grants between consecutive `cpu_clken` pulses; 0 = unlimited.
- `clk25` in 1 — master clock. Single clock domain.
- `reset` in 1 — synchronous, active-high.
- `cpu_clken` in 1 — CPU enable pulse, one cycle wide.
- `cpu_cs` in 1 — RAM chip select decoded from the CPU address.
- `cpu_we` in 1 — CPU write.
- `cpu_addr` in ADDR_WIDTH — CPU address, valid while `cpu_clken`.
- `cpu_wdata` in 8 — CPU write data.
- `cpu_rdata` out 8 — captured CPU read data, held until the next CPU read capture.
- `dma_req` in 1 — level request; must hold address/data/`dma_we` stable until acked.
- `dma_we` in 1 — DMA write.
- `dma_addr` in ADDR_WIDTH — DMA address.
- `dma_wdata` in 8 — DMA write data.
- `dma_ack` out 1 — combinational one-cycle grant pulse.
- `dma_rdata` out 8 — captured DMA read data.
- `dma_rvalid` out 1 — one-cycle pulse; `dma_rdata` is valid.
- `ram_addr` out ADDR_WIDTH — RAM address.
- `ram_w_en` out 1 — RAM write enable.
- `ram_din` out 8 — RAM write data.
- `ram_dout` in 8 — RAM read data, one-cycle latency.

## Operation
- Per-cycle owner selection:
  - CPU when `cpu_clken & cpu_cs`.
  - DMA when `dma_req & ~cpu_clken & ~throttled & ~reset`.
  - Otherwise idle.
- Idle cycles drive `ram_addr` = `cpu_addr`, `ram_w_en` = 0.
- `ram_w_en` = `cpu_we` for a CPU owner and `dma_we` for a DMA owner.
- Tag pipeline: a 2-bit registered tag (`NONE`/`CPU_RD`/`DMA_RD`) records the owner of the previous cycle's read. Writes tag `NONE`.
  - Tag `CPU_RD` → `cpu_rdata` <= `ram_dout`.
  - Tag `DMA_RD` → `dma_rdata` <= `ram_dout` and `dma_rvalid` <= 1.
  - Otherwise `dma_rvalid` <= 0.
- DMA write: `dma_ack` only; no `dma_rvalid`.
- Throttle counter:
  - Width ceil(log2(DMA_MAX_PER_SLOT+1)).
  - Cleared on `cpu_clken`; incremented on each DMA grant; saturates.
  - `throttled` = (count == DMA_MAX_PER_SLOT) when DMA_MAX_PER_SLOT != 0, else 0.
- CPU with `cpu_cs`=0 during `cpu_clken`: cycle is idle for the RAM; DMA is still blocked (fixed slot).
- Reset: tag <= `NONE`, `cpu_rdata` <= 8'h00, `dma_rdata` <= 8'h00, `dma_rvalid` <= 0, count <= 0. `dma_ack` = 0 while `reset` is high.
  - A DMA read acked in the cycle before reset is asserted produces no `dma_rvalid`.

## Timing
- CPU read: `cpu_clken` in cycle N → RAM samples address at end of N → `ram_dout` valid in N+1 → `cpu_rdata` updates at start of N+2. Held ≥ 23 cycles with the ÷25 divider.
- DMA read: `dma_ack` in cycle N → `dma_rvalid`/`dma_rdata` in N+2. Back-to-back grants give one `dma_rvalid` per cycle, in order.
- Write: takes effect at the end of the grant cycle. A read of the same address in N+1 returns the new value.
- DMA grant in N-1 followed by `cpu_clken` in N: DMA data is captured in N, CPU data in N+1. There is never a capture collision.
- Throughput: max DMA grants per 25-cycle period = min(24, DMA_MAX_PER_SLOT).

## Structure
- Shared package `apple1_pkg`: owner/tag encoding (`TAG_NONE`=0, `TAG_CPU_RD`=1, `TAG_DMA_RD`=2) and `RAM_ADDR_WIDTH`=13.
- No sub-modules: one module containing the owner mux, tag register, capture registers and throttle counter.

## Test plan
- CPU read 0x0123 (preloaded 8'hA5) with `cpu_clken` in cycle 10 → `cpu_rdata`=8'hA5 from cycle 12, unchanged through cycle 34.
- `dma_req` held continuously reading 0x0000..0x001F, DMA_MAX_PER_SLOT=8 → exactly 8 acks per 25-cycle period, none in the `cpu_clken` cycle; `dma_rvalid` data in address order.
- DMA read granted in the cycle before `cpu_clken`, CPU read same period → `dma_rdata` and `cpu_rdata` both correct, each `dma_rvalid` exactly once.
- CPU write 8'h3C to 0x1FFF, DMA read 0x1FFF next cycle → `dma_rdata`=8'h3C.
- DMA_MAX_PER_SLOT=0, `dma_req` always high → 24 acks per period; RAM writes only from the DMA write pattern.
- `reset` asserted one cycle after a DMA read ack → no `dma_rvalid`; all outputs at reset values; normal grants resume the cycle after deassertion.
